// File: rtl/gpio_pkg.sv
// gpio_pkg: default sizing shared by the GPIO input and output paths
package gpio_pkg;
  localparam int NUM_IN_DEF = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one-channel two-flop synchronizer, debounce counter and rise pulse
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic rise_next
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic s1, s2, done, level_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  // any sample that agrees with the accepted level restarts the count
  assign done = (s2 != level) && (cnt == CNT_MAX);
  assign level_next = done ? s2 : level;
  assign cnt_next = (s2 == level || done) ? '0 : cnt + 1'b1;
  assign rise_next = done && s2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
      rise <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      level <= level_next;
      cnt <= cnt_next;
      rise <= rise_next;
    end
  end
endmodule

// File: rtl/gpio_input.sv
// gpio_input: debounced button levels, rise pulses and a sticky event register with ack
module gpio_input
  import gpio_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] btn_in,
  output logic [NUM_IN-1:0] btn_level,
  output logic [NUM_IN-1:0] btn_rise,
  output logic              evt_valid,
  output logic [NUM_IN-1:0] evt_data,
  input  logic              evt_ack
);
  logic [NUM_IN-1:0] rise_next, pend;
  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk),
      .rst(rst),
      .btn(btn_in[i]),
      .level(btn_level[i]),
      .rise(btn_rise[i]),
      .rise_next(rise_next[i])
    );
  end
  // a rise landing with the ack survives the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else pend <= (evt_ack && evt_valid ? '0 : pend) | rise_next;
  end
  assign evt_valid = |pend;
  assign evt_data = pend;
endmodule

// File: tb/tb_gpio_input.sv
// tb_gpio_input: table, hand sequences and random stimulus against a sample-window model
module tb_gpio_input;
  localparam int N = 4;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic evt_ack = 1'b0;
  logic [N-1:0] btn_level, btn_rise, evt_data;
  logic evt_valid;
  int tests = 0;
  int fails = 0;

  gpio_input #(.NUM_IN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level), .btn_rise(btn_rise),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ack(evt_ack)
  );

  always #5 clk = ~clk;

  // model: a level flips once the last D synchronized samples all disagree with it;
  // synchronized sample seen at an edge is the raw pin taken two edges earlier
  logic [D:0][N-1:0] hist;
  logic [N-1:0] m_level, m_rise, m_pend;
  always @(posedge clk or posedge rst) begin : model
    logic [N-1:0] nl;
    logic diff;
    if (rst) begin
      hist <= '0;
      m_level <= '0;
      m_rise <= '0;
      m_pend <= '0;
    end else begin
      for (int c = 0; c < N; c++) begin
        diff = 1'b1;
        for (int k = 1; k <= D; k++) if (hist[k][c] == m_level[c]) diff = 1'b0;
        nl[c] = diff ? ~m_level[c] : m_level[c];
      end
      m_level <= nl;
      m_rise <= nl & ~m_level;
      m_pend <= ((evt_ack && |m_pend) ? '0 : m_pend) | (nl & ~m_level);
      hist <= {hist[D-1:0], btn_in};
    end
  end

  function automatic logic [3*N:0] pack(input logic [N-1:0] l, r, input logic v, input logic [N-1:0] d);
    return {l, r, v, d};
  endfunction

  task automatic check(input string name, input logic [3*N:0] exp);
    logic [3*N:0] act;
    act = pack(btn_level, btn_rise, evt_valid, evt_data);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got lvl=%b rise=%b vld=%b data=%b, want lvl=%b rise=%b vld=%b data=%b",
               name, act[3*N:2*N+1], act[2*N:N+1], act[N], act[N-1:0],
               exp[3*N:2*N+1], exp[2*N:N+1], exp[N], exp[N-1:0]);
    end
  endtask

  typedef struct {
    logic [N-1:0] btn;
    logic ack;
    int n;
    logic [N-1:0] lvl;
    logic [N-1:0] rse;
    logic vld;
    logic [N-1:0] dat;
  } step_t;
  step_t tbl[$];

  initial begin
    tbl.push_back('{4'b0001, 1'b0, 5, 4'b0000, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0001, 1'b0, 1, 4'b0001, 4'b0001, 1'b1, 4'b0001});
    tbl.push_back('{4'b0001, 1'b0, 1, 4'b0001, 4'b0000, 1'b1, 4'b0001});
    tbl.push_back('{4'b0001, 1'b0, 3, 4'b0001, 4'b0000, 1'b1, 4'b0001});
    tbl.push_back('{4'b0001, 1'b1, 1, 4'b0001, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0001, 1'b0, 1, 4'b0001, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0011, 1'b0, 3, 4'b0001, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0001, 1'b0, 6, 4'b0001, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0011, 1'b0, 4, 4'b0001, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0001, 1'b0, 1, 4'b0001, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0001, 1'b0, 1, 4'b0011, 4'b0010, 1'b1, 4'b0010});
    tbl.push_back('{4'b0001, 1'b1, 1, 4'b0011, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0001, 1'b0, 3, 4'b0001, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0101, 1'b0, 6, 4'b0101, 4'b0100, 1'b1, 4'b0100});
    tbl.push_back('{4'b1101, 1'b0, 5, 4'b0101, 4'b0000, 1'b1, 4'b0100});
    tbl.push_back('{4'b1101, 1'b1, 1, 4'b1101, 4'b1000, 1'b1, 4'b1000});
    tbl.push_back('{4'b1101, 1'b0, 1, 4'b1101, 4'b0000, 1'b1, 4'b1000});
    tbl.push_back('{4'b1101, 1'b1, 1, 4'b1101, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b1100, 1'b0, 5, 4'b1101, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b1100, 1'b0, 1, 4'b1100, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b1100, 1'b1, 1, 4'b1100, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b0000, 1'b0, 6, 4'b0000, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{4'b1001, 1'b0, 6, 4'b1001, 4'b1001, 1'b1, 4'b1001});
    tbl.push_back('{4'b1001, 1'b1, 1, 4'b1001, 4'b0000, 1'b0, 4'b0000});

    // reset with all pins high, then async reset mid-cycle from a busy state
    btn_in = 4'b1111;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset", pack(4'b1111, 4'b0000, 1'b1, 4'b1111));
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", pack('0, '0, 1'b0, '0));
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rel_5", pack('0, '0, 1'b0, '0));
    @(negedge clk);
    check("reset_rel_6", pack(4'b1111, 4'b1111, 1'b1, 4'b1111));
    @(negedge clk);
    check("reset_rel_7", pack(4'b1111, 4'b0000, 1'b1, 4'b1111));

    btn_in = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("idle", pack('0, '0, 1'b0, '0));
    foreach (tbl[i]) begin
      btn_in = tbl[i].btn;
      evt_ack = tbl[i].ack;
      repeat (tbl[i].n) @(negedge clk);
      check($sformatf("row%0d", i), pack(tbl[i].lvl, tbl[i].rse, tbl[i].vld, tbl[i].dat));
    end
    evt_ack = 1'b0;

    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(5) == 0) btn_in[c] = ~btn_in[c];
      evt_ack = ($urandom_range(3) == 0);
      @(negedge clk);
      check($sformatf("rand%0d", t), pack(m_level, m_rise, |m_pend, m_pend));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpio_input.md
# gpio_input

Input-direction GPIO block for the accelerator board: takes raw asynchronous push-button/switch pins, synchronizes and debounces them, and presents clean levels, single-cycle rising-edge pulses and a sticky event register with a valid/ack handshake to the control core. It is the counterpart of the LED-driving `gpio_module` output path. The control core uses it for start/mode buttons.

## Interface
- `NUM_IN`, default 4: number of input channels.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required to accept a level change, legal range 2 to 65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width, derived and not overridden.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `btn_in` in NUM_IN: raw pins, asynchronous to `clk`.
- `btn_level` out NUM_IN: debounced level per channel.
- `btn_rise` out NUM_IN: one-cycle pulse in the cycle `btn_level[i]` goes 0→1.
- `evt_valid` out 1: at least one latched rise event is pending.
- `evt_data` out NUM_IN: pending rise events, one bit per channel.
- `evt_ack` in 1: consumer clears pending events; only honoured while `evt_valid` = 1.

## Operation
- **Synchronizer:** per channel, two flops `s1` → `s2`, both reset to 0. No other logic samples `btn_in`.
- **Debounce state per channel:** `stable` (drives `btn_level`) and `cnt` (CNT_W bits).
  - If `s2` == `stable`: `cnt` ← 0.
  - If `s2` != `stable` and `cnt` < DEBOUNCE_CYCLES−1: `cnt` ← `cnt`+1.
  - If `s2` != `stable` and `cnt` == DEBOUNCE_CYCLES−1: `stable` ← `s2`, `cnt` ← 0.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes `stable`, because any matching sample zeroes `cnt`.
  - `cnt` never wraps.
- **Edge pulse:** `btn_rise[i]` is registered and set in the same edge that `stable[i]` goes 0→1. It is high for exactly one cycle. There is no falling-edge pulse.
- **Event register:** `pend` (NUM_IN bits), reset 0.
  - Next value = (`evt_ack` && `evt_valid` ? 0 : `pend`) | next `btn_rise`.
  - Consequence: a rise arriving in the same cycle as the ack is kept, not lost.
  - `evt_data` = `pend`; `evt_valid` = |`pend`. Both are registered or derived from registers only.
  - `evt_ack` while `evt_valid` = 0 has no effect.
  - Repeated rises on an already-pending bit merge into that bit; no counting.
- **Reset values:** on `rst`, whether idle or mid-count, all state clears immediately: `s1`, `s2`, `stable`, `cnt`, `pend` all 0. Outputs are then `btn_level` = 0, `btn_rise` = 0, `evt_valid` = 0, `evt_data` = 0. A pin held high through reset release is accepted as a rise after the normal latency.

## Timing
- **Latency, `btn_in` to `btn_level` / `btn_rise`:** with `btn_in` changing before edge 1 and held, `btn_level` updates at edge 2+DEBOUNCE_CYCLES (18 cycles at the default). `btn_rise` is high in that same cycle.
- **`btn_rise` to `evt_valid`:** `evt_valid` rises at the same edge as `btn_rise`.
- **Ack:** `evt_ack` sampled high at edge k clears `pend` at edge k, so `evt_valid` is low from k onward unless a new rise lands in that edge.
- **Channel independence:** channels are fully independent. Simultaneous rises on several channels set several `evt_data` bits in one cycle.

## Structure
- **Package `gpio_pkg`:** holds the default `NUM_IN` and `DEBOUNCE_CYCLES` constants, shared with `gpio_module`.
- **Sub-module `gpio_debounce`:** single-channel synchronizer plus debounce plus rise detect, with outputs `level` and `rise`. `gpio_input` instantiates it NUM_IN times in a generate loop and owns only the event register and handshake.

## Test plan
Bench runs with NUM_IN=4 and DEBOUNCE_CYCLES=4.

1. **Reset:** assert `rst` mid-cycle with `btn_in`=4'b1111 held. All outputs go 0 asynchronously. After release, `btn_level`=4'b1111 and `btn_rise`=4'b1111 exactly 6 cycles later.
2. **Clean press:** `btn_in[0]` 0→1 and held. `btn_level[0]` rises at edge 6. `btn_rise[0]` is high for 1 cycle. `evt_valid`=1 and `evt_data`=4'b0001 until ack.
3. **Glitch rejection:** `btn_in[1]` high for 3 cycles then low. `btn_level`, `btn_rise` and `evt_valid` stay 0. A 4-cycle pulse must produce a rise.
4. **Ack/rise collision:** ch2 pending, then assert `evt_ack` in the exact cycle ch3's rise lands. Afterwards `evt_data`=4'b1000 and `evt_valid`=1.
5. **Release and stray ack:** press then release ch0. `btn_level[0]` falls 6 cycles after release, with no pulse and no event. `evt_ack` with `evt_valid`=0 changes nothing.
6. **Multi-channel:** simultaneous press on ch0 and ch3. One `evt_data`=4'b1001 is delivered, and a single ack clears both bits.
